// File: rtl/rca_use_sequencer_pkg.sv
// rca_config: shared constants for the RCA use sequencer.
//   - default sizing of the sequencer (accelerator count, widths, watchdog)
//   - RCA use instruction encoding (opcode and field bit positions)
//   - sequencer state enumeration
package rca_config;

  localparam int NUM_RCAS       = 4;
  localparam int XLEN           = 32;
  localparam int ID_WIDTH       = 3;
  localparam int TIMEOUT_CYCLES = 1024;

  localparam logic [6:0] RCA_USE_OPCODE = 7'h2B;
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int IDX_MSB    = 14;
  localparam int IDX_LSB    = 12;
  localparam int NFB_BIT    = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FB_WB,
    S_ARMED,
    S_RUN,
    S_RES_WB,
    S_REDIRECT
  } state_t;

endpackage

// File: rtl/rca_use_sequencer_decode.sv
// rca_use_decode: combinational decoder for the RCA use instruction.
//   instr   - instruction word
//   is_use  - opcode is the RCA use opcode
//   is_nfb  - no-feedback (launch) form; 0 = feedback (arm) form
//   rca_idx - accelerator index field
//   legal   - RCA use instruction naming an existing accelerator
module rca_use_decode #(
  parameter int NUM_RCAS = 4,
  parameter int XLEN     = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic            is_use,
  output logic            is_nfb,
  output logic [2:0]      rca_idx,
  output logic            legal
);
  import rca_config::*;

  assign is_use  = (instr[OPCODE_MSB:OPCODE_LSB] == RCA_USE_OPCODE);
  assign is_nfb  = instr[NFB_BIT];
  assign rca_idx = instr[IDX_MSB:IDX_LSB];
  // Widen by one bit so NUM_RCAS = 8 still fits in the comparison.
  assign legal   = is_use && ({1'b0, rca_idx} < 4'(NUM_RCAS));

  // Bits outside the decoded fields carry no meaning here.
  logic unused_instr;
  assign unused_instr = ^{instr[XLEN-1:NFB_BIT+1], instr[NFB_BIT-1:IDX_MSB+1],
                          instr[IDX_LSB-1:OPCODE_MSB+1]};

endmodule

// File: rtl/rca_use_sequencer.sv
// rca_use_sequencer: executes the FB (arm) / NFB (launch) RCA use pair.
//   issue_*      - instruction acceptance handshake (issue_ready out)
//   wb_*         - writeback of result/ID, held until wb_ack
//   rca_start    - one-hot launch pulse for the armed accelerator
//   rca_sel      - armed accelerator index (selects rca_result / sbb_addr)
//   rca_done     - per-accelerator completion pulses
//   redirect*    - one-cycle fetch redirect to the captured exit address
//   error        - sticky error flag, cleared only by reset
module rca_use_sequencer #(
  parameter int NUM_RCAS       = rca_config::NUM_RCAS,
  parameter int XLEN           = rca_config::XLEN,
  parameter int ID_WIDTH       = rca_config::ID_WIDTH,
  parameter int TIMEOUT_CYCLES = rca_config::TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_new_request,
  input  logic [XLEN-1:0]             issue_instr,
  input  logic [ID_WIDTH-1:0]         issue_id,
  output logic                        issue_ready,
  output logic                        wb_done,
  output logic [ID_WIDTH-1:0]         wb_id,
  output logic [XLEN-1:0]             wb_rd,
  input  logic                        wb_ack,
  output logic [NUM_RCAS-1:0]         rca_start,
  output logic [$clog2(NUM_RCAS)-1:0] rca_sel,
  input  logic [NUM_RCAS-1:0]         rca_done,
  input  logic [XLEN-1:0]             rca_result,
  input  logic [XLEN-1:0]             sbb_addr,
  output logic                        redirect,
  output logic [XLEN-1:0]             redirect_pc,
  output logic                        error
);
  import rca_config::*;

  localparam int SEL_W = $clog2(NUM_RCAS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic       dec_is_use, dec_is_nfb, dec_legal;
  logic [2:0] dec_idx;

  rca_use_decode #(.NUM_RCAS(NUM_RCAS), .XLEN(XLEN)) u_decode (
    .instr   (issue_instr),
    .is_use  (dec_is_use),
    .is_nfb  (dec_is_nfb),
    .rca_idx (dec_idx),
    .legal   (dec_legal)
  );

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [ID_WIDTH-1:0] id_reg, id_next;
  logic [XLEN-1:0]     rd_reg, rd_next;
  logic [XLEN-1:0]     sbb_reg, sbb_next;
  logic                err_reg, err_next;
  logic                ok_reg, ok_next;       // run completed normally
  logic                first_reg, first_next; // RUN entry (start) cycle
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic unused_is_use;
  assign unused_is_use = dec_is_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      sel_reg   <= '0;
      id_reg    <= '0;
      rd_reg    <= '0;
      sbb_reg   <= '0;
      err_reg   <= 1'b0;
      ok_reg    <= 1'b0;
      first_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      id_reg    <= id_next;
      rd_reg    <= rd_next;
      sbb_reg   <= sbb_next;
      err_reg   <= err_next;
      ok_reg    <= ok_next;
      first_reg <= first_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    id_next    = id_reg;
    rd_next    = rd_reg;
    sbb_next   = sbb_reg;
    err_next   = err_reg;
    ok_next    = ok_reg;
    first_next = 1'b0;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (issue_new_request) begin
          id_next = issue_id;
          rd_next = '0;
          if (dec_legal && !dec_is_nfb) begin
            sel_next   = SEL_W'(dec_idx);
            state_next = S_FB_WB;
          end else begin
            err_next   = 1'b1;
            ok_next    = 1'b0;
            state_next = S_RES_WB;
          end
        end
      end
      S_FB_WB: begin
        if (wb_ack) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (issue_new_request) begin
          id_next = issue_id;
          ok_next = 1'b0;
          if (dec_legal && dec_is_nfb && (dec_idx == 3'(sel_reg))) begin
            sbb_next   = sbb_addr;
            first_next = 1'b1;
            cnt_next   = '0;
            state_next = S_RUN;
          end else begin
            err_next   = 1'b1;
            rd_next    = '0;
            state_next = S_RES_WB;
          end
        end
      end
      S_RUN: begin
        // Completion is not honoured in the start cycle itself.
        if (first_reg) begin
          cnt_next = '0;
        end else if (rca_done[sel_reg]) begin
          rd_next    = rca_result;
          ok_next    = 1'b1;
          state_next = S_RES_WB;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rd_next    = '0;
          err_next   = 1'b1;
          ok_next    = 1'b0;
          state_next = S_RES_WB;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_RES_WB: begin
        if (wb_ack) state_next = ok_reg ? S_REDIRECT : S_IDLE;
      end
      S_REDIRECT: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign issue_ready = (state_reg == S_IDLE) || (state_reg == S_ARMED);
  assign wb_done     = (state_reg == S_FB_WB) || (state_reg == S_RES_WB);
  assign wb_id       = id_reg;
  assign wb_rd       = rd_reg;
  assign rca_sel     = sel_reg;
  assign rca_start   = (state_reg == S_RUN && first_reg)
                       ? ({{(NUM_RCAS-1){1'b0}}, 1'b1} << sel_reg) : '0;
  assign redirect    = (state_reg == S_REDIRECT);
  assign redirect_pc = redirect ? sbb_reg : '0;
  assign error       = err_reg;

endmodule

// File: tb/tb_rca_use_sequencer.sv
module tb_rca_use_sequencer;

  localparam int NR = 4;
  localparam int T  = 16;

  logic        clk;
  logic        rst_n;
  logic        issue_new_request;
  logic [31:0] issue_instr;
  logic [2:0]  issue_id;
  logic        issue_ready;
  logic        wb_done;
  logic [2:0]  wb_id;
  logic [31:0] wb_rd;
  logic        wb_ack;
  logic [3:0]  rca_start;
  logic [1:0]  rca_sel;
  logic [3:0]  rca_done;
  logic [31:0] rca_result;
  logic [31:0] sbb_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        error;

  int pass_cnt = 0;
  int total_cnt = 0;

  rca_use_sequencer #(.NUM_RCAS(NR), .XLEN(32), .ID_WIDTH(3), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_new_request(issue_new_request), .issue_instr(issue_instr),
    .issue_id(issue_id), .issue_ready(issue_ready),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
    .rca_start(rca_start), .rca_sel(rca_sel), .rca_done(rca_done),
    .rca_result(rca_result), .sbb_addr(sbb_addr),
    .redirect(redirect), .redirect_pc(redirect_pc), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  id;
    logic        exp_err;
    logic [3:0]  exp_start;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [2:0] id);
    issue_new_request = 1'b1;
    issue_instr = instr;
    issue_id = id;
    step();
    issue_new_request = 1'b0;
    issue_instr = '0;
  endtask

  task automatic ack();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] nfb;

    vecs[0] = '{32'h0000102B, 3'd2, 1'b0, 4'b0010};
    vecs[1] = '{32'h0000002B, 3'd1, 1'b0, 4'b0001};
    vecs[2] = '{32'h0000302B, 3'd5, 1'b0, 4'b1000};
    vecs[3] = '{32'hFDFFA0AB, 3'd6, 1'b0, 4'b0100};
    vecs[4] = '{32'h0000402B, 3'd4, 1'b1, 4'b0000};
    vecs[5] = '{32'h0200102B, 3'd3, 1'b1, 4'b0000};
    vecs[6] = '{32'h00001033, 3'd7, 1'b1, 4'b0000};

    rst_n = 1'b0;
    issue_new_request = 1'b0;
    issue_instr = '0;
    issue_id = '0;
    wb_ack = 1'b0;
    rca_done = '0;
    rca_result = '0;
    sbb_addr = 32'h8000_0100;
    #8;
    check("reset issue_ready", 32'(issue_ready), 32'd1);
    check("reset wb_done", 32'(wb_done), 32'd0);
    check("reset wb_id", 32'(wb_id), 32'd0);
    check("reset wb_rd", wb_rd, 32'd0);
    check("reset rca_start", 32'(rca_start), 32'd0);
    check("reset rca_sel", 32'(rca_sel), 32'd0);
    check("reset redirect", 32'(redirect), 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);
    check("reset error", 32'(error), 32'd0);
    #4 rst_n = 1'b1;
    step();

    // Table: first instruction from IDLE, ack, then the matching NFB form.
    for (int i = 0; i < 7; i++) begin
      pulse_reset();
      issue(vecs[i].instr, vecs[i].id);
      $display("vec %0d instr %h id %0d: wb_done %0d wb_id %0d wb_rd %h error %0d",
               i, vecs[i].instr, vecs[i].id, wb_done, wb_id, wb_rd, error);
      check("vec wb_done", 32'(wb_done), 32'd1);
      check("vec wb_id", 32'(wb_id), 32'(vecs[i].id));
      check("vec wb_rd", wb_rd, 32'd0);
      check("vec error", 32'(error), 32'(vecs[i].exp_err));
      check("vec issue_ready busy", 32'(issue_ready), 32'd0);
      ack();
      check("vec wb_done after ack", 32'(wb_done), 32'd0);
      check("vec redirect after ack", 32'(redirect), 32'd0);
      check("vec ready after ack", 32'(issue_ready), 32'd1);
      nfb = vecs[i].instr | 32'h0200_0000;
      issue(nfb, 3'd0);
      check("vec rca_start", 32'(rca_start), 32'(vecs[i].exp_start));
      // Asynchronous reset while possibly mid-RUN.
      rst_n = 1'b0;
      #1;
      check("vec async rst rca_start", 32'(rca_start), 32'd0);
      check("vec async rst wb_done", 32'(wb_done), 32'd0);
      check("vec async rst error", 32'(error), 32'd0);
      check("vec async rst ready", 32'(issue_ready), 32'd1);
      #2 rst_n = 1'b1;
      step();
      check("vec no restart", 32'(rca_start), 32'd0);
    end

    // Full FB/NFB flow with ignored completions and redirect.
    pulse_reset();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("stray ack ignored", 32'(issue_ready), 32'd1);
    issue(32'h0000102B, 3'd2);
    check("fb wb_id", 32'(wb_id), 32'd2);
    check("fb rca_sel", 32'(rca_sel), 32'd1);
    ack();
    sbb_addr = 32'h8000_0100;
    issue(32'h0200102B, 3'd3);
    $display("nfb accept: rca_start %b", rca_start);
    check("flow rca_start", 32'(rca_start), 32'b0010);
    rca_done = 4'b0011;
    rca_result = 32'hDEAD;
    sbb_addr = 32'h1234_5678;
    step();
    check("start-cycle done ignored", 32'(wb_done), 32'd0);
    check("start single pulse", 32'(rca_start), 32'd0);
    rca_done = 4'b0001;
    rca_result = 32'hBEEF;
    issue_new_request = 1'b1;
    issue_instr = 32'h0000002B;
    step();
    issue_new_request = 1'b0;
    check("other done ignored", 32'(wb_done), 32'd0);
    check("busy request ignored", 32'(error), 32'd0);
    rca_done = 4'b0010;
    rca_result = 32'hCAFE;
    step();
    rca_done = '0;
    $display("done: wb_done %0d wb_rd %h wb_id %0d", wb_done, wb_rd, wb_id);
    check("flow wb_done", 32'(wb_done), 32'd1);
    check("flow wb_rd", wb_rd, 32'hCAFE);
    check("flow wb_id", 32'(wb_id), 32'd3);
    step();
    check("flow wb_done held", 32'(wb_done), 32'd1);
    ack();
    $display("redirect %0d pc %h", redirect, redirect_pc);
    check("flow redirect", 32'(redirect), 32'd1);
    check("flow redirect_pc", redirect_pc, 32'h8000_0100);
    check("flow ready during redirect", 32'(issue_ready), 32'd0);
    step();
    check("flow redirect one cycle", 32'(redirect), 32'd0);
    check("flow ready after redirect", 32'(issue_ready), 32'd1);
    check("flow error clean", 32'(error), 32'd0);

    // FB index 2, then NFB index 3: error completion.
    pulse_reset();
    issue(32'h0000202B, 3'd1);
    ack();
    issue(32'h0200302B, 3'd4);
    check("mismatch no start", 32'(rca_start), 32'd0);
    check("mismatch wb_done", 32'(wb_done), 32'd1);
    check("mismatch wb_rd", wb_rd, 32'd0);
    check("mismatch wb_id", 32'(wb_id), 32'd4);
    check("mismatch error", 32'(error), 32'd1);
    ack();
    check("mismatch no redirect", 32'(redirect), 32'd0);
    check("mismatch idle", 32'(issue_ready), 32'd1);
    step();
    check("mismatch error sticky", 32'(error), 32'd1);
    check("mismatch still no redirect", 32'(redirect), 32'd0);

    // Watchdog expiry.
    pulse_reset();
    issue(32'h0000002B, 3'd0);
    ack();
    issue(32'h0200002B, 3'd1);
    check("wdog rca_start", 32'(rca_start), 32'b0001);
    for (int k = 0; k < T; k++) step();
    check("wdog not yet", 32'(wb_done), 32'd0);
    step();
    $display("watchdog: wb_done %0d wb_rd %h error %0d", wb_done, wb_rd, error);
    check("wdog wb_done", 32'(wb_done), 32'd1);
    check("wdog wb_rd", wb_rd, 32'd0);
    check("wdog error", 32'(error), 32'd1);
    ack();
    check("wdog no redirect", 32'(redirect), 32'd0);
    check("wdog idle", 32'(issue_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
